// File: rtl/conv_decoder_pkg.sv
// conv_decoder_pkg: constants shared with the weight memory and the fetcher state encoding
package conv_decoder_pkg;
    localparam int NUM_FILTERS = 16;
    localparam int SEL_W = 4;
    localparam int W_W = 18;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} fetch_state_t;
endpackage

// File: rtl/conv_decoder_weights_fetcher.sv
// conv_decoder_weights_fetcher: walks all filters through the weight memory and streams each weight downstream
module conv_decoder_weights_fetcher
    import conv_decoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_start,
    output logic [SEL_W-1:0]        mem_filter_sel,
    input  logic signed [W_W-1:0]   mem_w,
    input  logic                    mem_ready,
    output logic signed [W_W-1:0]   w_out,
    output logic [SEL_W-1:0]        w_idx,
    output logic                    w_valid,
    input  logic                    w_accept
);
    fetch_state_t state, state_n;
    logic [SEL_W-1:0] idx, idx_n;
    logic last;
    assign last = idx == SEL_W'(NUM_FILTERS - 1);
    always_comb begin
        state_n = state;
        idx_n = idx;
        case (state)
            IDLE: if (load) begin
                state_n = REQ;
                idx_n = '0;
            end
            REQ: state_n = WAIT;
            WAIT: if (mem_ready) state_n = HOLD;
            HOLD: if (w_accept) begin
                state_n = last ? DONE : REQ;
                idx_n = last ? idx : idx + 1'b1;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            idx_n = '0;
        end
    end
    // Outputs are decoded from the next state so every one of them is a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            mem_start <= 1'b0;
            mem_filter_sel <= '0;
            w_out <= '0;
            w_idx <= '0;
            w_valid <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            mem_start <= state_n == REQ;
            mem_filter_sel <= idx_n;
            w_valid <= state_n == HOLD;
            done <= state_n == DONE;
            busy <= state_n != IDLE;
            if (state == WAIT && state_n == HOLD) begin
                w_out <= mem_w;
                w_idx <= idx;
            end
        end
    end
endmodule

// File: tb/tb_conv_decoder_weights_fetcher.sv
// tb_conv_decoder_weights_fetcher: weight-memory responder plus a visibility-time model of the fetch stream
module tb_conv_decoder_weights_fetcher;
    import conv_decoder_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, abort = 1'b0, w_accept = 1'b0, stall = 1'b0;
    logic busy, done, mem_start, w_valid, mem_rdy_q, mem_ready;
    logic [SEL_W-1:0] mem_filter_sel, w_idx;
    logic signed [W_W-1:0] mem_w, w_out;
    logic signed [W_W-1:0] wmem [NUM_FILTERS];
    int vectors = 0, errors = 0, n_starts = 0, n_done = 0;
    int starts [NUM_FILTERS];

    typedef struct {int edge_no; int idx; int w;} vec_t;
    vec_t tbl [NUM_FILTERS];
    localparam int REF_W [NUM_FILTERS] = '{63, 125, 6, -137, 90, -27, 141, -7, 10, -154, -1, -45, 141, 128, -57, -100};

    always #5 clk = ~clk;

    conv_decoder_weights_fetcher dut (
        .clk(clk), .rst_n(rst_n), .load(load), .abort(abort), .busy(busy), .done(done),
        .mem_start(mem_start), .mem_filter_sel(mem_filter_sel), .mem_w(mem_w), .mem_ready(mem_ready),
        .w_out(w_out), .w_idx(w_idx), .w_valid(w_valid), .w_accept(w_accept)
    );

    // Weight memory: word appears the cycle after start is sampled, ready sticks high after the first read
    assign mem_ready = mem_rdy_q & ~stall;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mem_rdy_q <= 1'b0;
            mem_w <= '0;
        end else if (mem_start) begin
            mem_rdy_q <= 1'b1;
            mem_w <= wmem[mem_filter_sel];
        end

    always @(posedge clk) begin
        if (mem_start) begin
            n_starts <= n_starts + 1;
            starts[mem_filter_sel] <= starts[mem_filter_sel] + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst mem_start", mem_start, 0);
        chk("rst mem_filter_sel", mem_filter_sel, 0);
        chk("rst w_out", w_out, 0);
        chk("rst w_idx", w_idx, 0);
        chk("rst w_valid", w_valid, 0);
        @(negedge clk) rst_n = 1'b1;
    endtask

    // Model: weight i is visible from edge vis; it is taken at the first later edge with accept high,
    // after which the next weight is visible two edges later, or done pulses at that edge for the last one.
    task automatic run_model(input int mode, input string tag);
        int vis = 2, i = 0, done_at = -1, s0, d0;
        int st0 [NUM_FILTERS];
        logic acc, vexp;
        s0 = n_starts;
        d0 = n_done;
        foreach (st0[k]) st0[k] = starts[k];
        w_accept = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int e = 1; e < 400; e++) begin
            case (mode)
                1: acc = !(i == 3 && e > vis && e <= vis + 5);
                2: acc = 1'($urandom_range(0, 1));
                default: acc = 1'b1;
            endcase
            w_accept = acc;
            load = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            if (i < NUM_FILTERS && vis < e && acc) begin
                i++;
                if (i == NUM_FILTERS) done_at = e;
                else vis = e + 2;
            end
            vexp = i < NUM_FILTERS && vis <= e;
            chk({tag, " w_valid"}, w_valid, vexp);
            if (vexp) begin
                chk({tag, " w_idx"}, w_idx, i);
                chk({tag, " w_out"}, w_out, wmem[i]);
            end
            chk({tag, " done"}, done, e == done_at);
            chk({tag, " busy"}, busy, done_at < 0 || e <= done_at);
            if (done_at >= 0 && e > done_at) break;
        end
        load = 1'b0;
        chk({tag, " done count"}, n_done - d0, 1);
        chk({tag, " start count"}, n_starts - s0, NUM_FILTERS);
        foreach (st0[k]) chk({tag, " starts per idx"}, starts[k] - st0[k], 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, s0, d0;
        foreach (wmem[k]) wmem[k] = W_W'(REF_W[k]);
        foreach (tbl[t]) tbl[t] = '{2 + 3 * t, t, REF_W[t]};
        do_reset();

        // Full sequence against the fixed table
        d0 = n_done;
        w_accept = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        e = 0;
        foreach (tbl[t]) begin
            while (e < tbl[t].edge_no) begin
                tick();
                e++;
            end
            chk("seq w_valid", w_valid, 1);
            chk("seq w_idx", w_idx, tbl[t].idx);
            chk("seq w_out", w_out, tbl[t].w);
        end
        chk("seq done early", done, 0);
        tick();
        chk("seq done edge48", done, 1);
        chk("seq busy edge48", busy, 1);
        tick();
        chk("seq busy edge49", busy, 0);
        chk("seq done edge49", done, 0);
        chk("seq done count", n_done - d0, 1);

        run_model(1, "stall");

        // Abort with accept in the same cycle, then restart from index 0
        d0 = n_done;
        w_accept = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (23) tick();
        chk("abort pre w_idx", w_idx, 7);
        chk("abort pre w_valid", w_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort w_valid", w_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort mem_start", mem_start, 0);
        repeat (5) tick();
        chk("abort no done", n_done - d0, 0);
        chk("abort stays idle", busy, 0);
        run_model(0, "restart");

        run_model(3, "loadspam");
        for (int r = 0; r < 4; r++) begin
            foreach (wmem[k]) wmem[k] = W_W'($urandom);
            run_model(2, "rand");
        end
        foreach (wmem[k]) wmem[k] = W_W'(REF_W[k]);

        // Asynchronous reset while waiting on the memory
        w_accept = 1'b1;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk("arst pre busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst w_valid", w_valid, 0);
        chk("arst mem_start", mem_start, 0);
        chk("arst busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        s0 = n_starts;
        repeat (6) tick();
        chk("arst idle busy", busy, 0);
        chk("arst no restart", n_starts - s0, 0);

        // Stalled memory on the first read
        do_reset();
        stall = 1'b1;
        w_accept = 1'b0;
        s0 = n_starts;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("stub w_valid", w_valid, 0);
            chk("stub busy", busy, 1);
        end
        stall = 1'b0;
        tick();
        chk("stub capture w_valid", w_valid, 1);
        chk("stub capture w_idx", w_idx, 0);
        chk("stub capture w_out", w_out, 63);
        chk("stub single start", n_starts - s0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/conv_decoder_weights_fetcher.md
Name: conv_decoder_weights_fetcher

Overview:
Requester side of the decoder weight-memory read interface. On a load command it walks filter_sel 0..NUM_FILTERS-1, pulses the memory's start, captures each returned signed weight, and presents it downstream on a valid/accept stream tagged with its filter index. It sits between the conv decoder controller (which issues load and waits for done) and the conv decoder datapath (which consumes weights in order).

Parameters:
NUM_FILTERS, 16, number of weights fetched per load; must be ≤ 2**SEL_W.
SEL_W, 4, filter select / index width.
W_W, 18, signed weight width; matches the memory's output word.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
load  in  1  start a full fetch sequence; sampled only in IDLE.
abort  in  1  synchronous abort; returns to IDLE from any state.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse after the last weight is accepted.
mem_start  out  1  read strobe to the weight memory; high exactly one cycle per read.
mem_filter_sel  out  SEL_W  read address; valid while mem_start is high.
mem_w  in  W_W signed  weight from memory; valid the cycle after mem_start is sampled.
mem_ready  in  1  memory ready flag; sticky high after the first read.
w_out  out  W_W signed  weight presented downstream.
w_idx  out  SEL_W  filter index of w_out.
w_valid  out  1  w_out/w_idx valid.
w_accept  in  1  downstream takes the word when w_valid && w_accept at the clock edge.

Behaviour:
- Reset (rst_n low, async): state=IDLE, idx=0, mem_start=0, mem_filter_sel=0, w_out=0, w_idx=0, w_valid=0, done=0, busy=0. Reset asserted mid-sequence discards everything; no done.
- All outputs are registered. mem_filter_sel is a registered copy of idx.
- FSM states: IDLE, REQ, WAIT, HOLD, DONE.
- IDLE: load=1 -> REQ, idx<=0. load in any other state is ignored (no queueing).
- REQ: mem_start=1, mem_filter_sel=idx for this one cycle -> WAIT.
- WAIT: mem_start=0. If mem_ready=1, w_out<=mem_w, w_idx<=idx, w_valid<=1 -> HOLD. If mem_ready=0, remain in WAIT; this only occurs with a stalled memory.
- HOLD: w_valid=1. w_out and w_idx are held stable until accepted. On w_accept: w_valid<=0; if idx==NUM_FILTERS-1 -> DONE, else idx<=idx+1 -> REQ.
- DONE: done=1 for exactly one cycle -> IDLE. busy is high in DONE.
- abort=1 in any state: next state IDLE, w_valid<=0, mem_start<=0, idx<=0, no done. abort has priority over load and over w_accept in the same cycle.
- w_accept while w_valid=0 is ignored.
- Latency: with load sampled at edge k, weight i becomes visible after edge k+2+3i when w_accept is held high.
  - Last weight visible after edge k+47.
  - done visible after edge k+48.
  - busy falls after edge k+49.
  - Each cycle w_accept is low adds one cycle.
- The index never wraps. The sequence terminates at NUM_FILTERS-1; the next load restarts at 0.
- No arithmetic on weights. mem_w passes through bit-exact, sign preserved.

Decomposition:
- Shared package conv_decoder_pkg holds:
  - NUM_FILTERS, SEL_W and W_W constants, shared with the weight memory;
  - the fetcher state enum {IDLE, REQ, WAIT, HOLD, DONE}.
- No sub-module. The FSM and index counter are small enough to stay in one module.
- The bench instantiates the existing weight memory as the responder.

Test Plan:
1. Reset, then load at edge 0 with w_accept=1 and the real memory attached -> w_valid outputs in order 63, 125, 6, -137, 90, -27, 141, -7, 10, -154, -1, -45, 141, 128, -57, -100. w_idx runs 0..15, the first word appears after edge 2 and the last after edge 47. done pulses once after edge 48; busy is low after edge 49.
2. Backpressure: hold w_accept=0 for 5 cycles on idx 3 -> w_out stays -137 and w_idx stays 3 throughout. Exactly one mem_start per index; done is delayed by 5 cycles.
3. Abort at idx 7 in HOLD with w_accept=1 in the same cycle -> IDLE next cycle, w_valid=0, no done. A following load restarts at idx 0 with weight 63.
4. load pulsed repeatedly while busy -> ignored: a single 16-word sequence and a single done.
5. Drop rst_n asynchronously mid-WAIT (between edges) -> w_valid, mem_start and busy go to 0 immediately. After release, an idle fetcher does not restart without load.
6. Stub memory holding mem_ready=0 for 4 cycles on the first read -> fetcher stays in WAIT and captures on the first cycle mem_ready=1. No extra mem_start is issued.
